// File: rtl/iir_deemph_pkg.sv
// Shared defaults, FSM state type and clamp helper for the
// de-emphasis IIR filter (saturation helper under IIR_SAT_EN).
package iir_deemph_pkg;

    localparam int QUANT_BITS_DEF = 10;

    localparam logic signed [31:0] B0_DEF = 32'sd178;
    localparam logic signed [31:0] B1_DEF = 32'sd178;
    localparam logic signed [31:0] A1_DEF = 32'sd666;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WRITE
    } state_t;

`ifdef IIR_SAT_EN
    // Clamp a 34-bit sum into the signed 32-bit range.
    function automatic logic signed [31:0] sat32(
        input logic signed [33:0] v
    );
        if (v > 34'sh0_7FFF_FFFF)
            return 32'sh7FFF_FFFF;
        else if (v < -34'sh0_8000_0000)
            return 32'sh8000_0000;
        else
            return v[31:0];
    endfunction
`endif

endpackage

// File: rtl/iir_term_mult.sv
// One filter term: 32x32 signed product, floor-shifted right by
// QUANT_BITS, truncated. Ports: a, b (signed in), p (signed out).
module iir_term_mult
    import iir_deemph_pkg::*;
#(
    parameter int QUANT_BITS = QUANT_BITS_DEF
) (
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    output logic signed [31:0] p
);

    logic signed [63:0] full;

    assign full = 64'(a) * 64'(b);
    assign p    = 32'(full >>> QUANT_BITS);

endmodule

// File: rtl/iir_deemph.sv
// First-order IIR de-emphasis between two FIFOs, one shared
// multiplier, one term per cycle. Ports: clock, reset (sync, high),
// in_rd_en/in_empty/in_dout (upstream), out_wr_en/out_full/out_din
// (downstream). Macro IIR_SAT_EN selects a clamped 3-term sum.
module iir_deemph
    import iir_deemph_pkg::*;
#(
    parameter int                 QUANT_BITS = QUANT_BITS_DEF,
    parameter logic signed [31:0] B0         = B0_DEF,
    parameter logic signed [31:0] B1         = B1_DEF,
    parameter logic signed [31:0] A1         = A1_DEF
) (
    input  logic               clock,
    input  logic               reset,
    output logic               in_rd_en,
    input  logic               in_empty,
    input  logic signed [31:0] in_dout,
    output logic               out_wr_en,
    input  logic               out_full,
    output logic signed [31:0] out_din
);

`ifdef IIR_SAT_EN
    localparam int ACC_W = 34;
`else
    localparam int ACC_W = 32;
`endif

    state_t                   state;
    logic [1:0]               idx;
    logic signed [31:0]       x_cur;
    logic signed [31:0]       x_prev;
    logic signed [31:0]       y_prev;
    logic signed [ACC_W-1:0]  acc;
    logic                     rst_q;

    logic signed [31:0]       coef;
    logic signed [31:0]       opnd;
    logic signed [31:0]       term;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  fin;
    logic                     rd_ok;
    logic                     wr_ok;

    always_comb begin
        coef = A1;
        opnd = y_prev;
        case (idx)
            2'd0: begin
                coef = B0;
                opnd = x_cur;
            end
            2'd1: begin
                coef = B1;
                opnd = x_prev;
            end
            default: begin
                coef = A1;
                opnd = y_prev;
            end
        endcase
    end

    iir_term_mult #(
        .QUANT_BITS(QUANT_BITS)
    ) u_mult (
        .a(coef),
        .b(opnd),
        .p(term)
    );

    assign sum = acc + ACC_W'(term);

`ifdef IIR_SAT_EN
    assign fin = ACC_W'(sat32(sum));
`else
    assign fin = sum;
`endif

    // rst_q keeps the pop low on the first cycle after reset.
    assign rd_ok = (state == S_IDLE) && !in_empty
                && !reset && !rst_q;
    assign wr_ok = (state == S_WRITE) && !out_full
                && !reset;

    assign in_rd_en  = rd_ok;
    assign out_wr_en = wr_ok;
    assign out_din   = wr_ok ? acc[31:0] : 32'sd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= 2'd0;
            x_cur  <= '0;
            x_prev <= '0;
            y_prev <= '0;
            acc    <= '0;
            rst_q  <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (rd_ok) begin
                        x_cur <= in_dout;
                        acc   <= '0;
                        idx   <= 2'd0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (idx == 2'd2) begin
                        acc   <= fin;
                        state <= S_WRITE;
                    end else begin
                        acc <= sum;
                        idx <= idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (wr_ok) begin
                        x_prev <= x_cur;
                        y_prev <= acc[31:0];
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_deemph.sv
// Directed bench for iir_deemph: vector table plus back-pressure,
// empty-input, saturation, rounding and mid-sample reset sequences.
module tb_iir_deemph;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               in_rd_en;
    logic               in_empty = 1'b1;
    logic signed [31:0] in_dout = '0;
    logic               out_wr_en;
    logic               out_full = 1'b0;
    logic signed [31:0] out_din;

    logic               s_rd;
    logic               s_empty = 1'b1;
    logic signed [31:0] s_dout = '0;
    logic               s_wr;
    logic signed [31:0] s_din;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_rd  = 0;
    int n_wr  = 0;

    iir_deemph dut (
        .clock    (clock),
        .reset    (reset),
        .in_rd_en (in_rd_en),
        .in_empty (in_empty),
        .in_dout  (in_dout),
        .out_wr_en(out_wr_en),
        .out_full (out_full),
        .out_din  (out_din)
    );

    iir_deemph #(
        .B0(32'sd1024),
        .B1(32'sd1024),
        .A1(32'sd0)
    ) u_sat (
        .clock    (clock),
        .reset    (reset),
        .in_rd_en (s_rd),
        .in_empty (s_empty),
        .in_dout  (s_dout),
        .out_wr_en(s_wr),
        .out_full (1'b0),
        .out_din  (s_din)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)",
                     nm, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Protocol invariants, sampled mid-cycle.
    always begin
        @(negedge clock);
        #1;
        if (in_rd_en) n_rd++;
        if (out_wr_en) n_wr++;
        chk("excl", {31'b0, in_rd_en & out_wr_en}, 32'd0);
        if (!out_wr_en) chk("din_zero", out_din, 32'd0);
        chk("s_excl", {31'b0, s_rd & s_wr}, 32'd0);
        if (!s_wr) chk("s_din_zero", s_din, 32'd0);
    end

    // All tasks start and return at a falling edge.
    task automatic push(input logic [31:0] x, output int rc);
        int k = 0;
        in_dout  = x;
        in_empty = 1'b0;
        #1;
        while (!in_rd_en && k < 50) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk("rd_timeout", {31'b0, in_rd_en}, 32'd1);
        rc = cyc;
        @(negedge clock);
        in_empty = 1'b1;
    endtask

    task automatic wait_wr(output logic [31:0] v, output int wc);
        int k = 0;
        #1;
        while (!out_wr_en && k < 50) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk("wr_timeout", {31'b0, out_wr_en}, 32'd1);
        v  = out_din;
        wc = cyc;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        out_full = 1'b0;
        in_empty = 1'b0;
        in_dout  = 32'sd77;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_rd", {31'b0, in_rd_en}, 32'd0);
            chk("rst_wr", {31'b0, out_wr_en}, 32'd0);
            chk("rst_din", out_din, 32'd0);
            @(negedge clock);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_rd", {31'b0, in_rd_en}, 32'd0);
        chk("post_rst_din", out_din, 32'd0);
        in_empty = 1'b1;
        @(negedge clock);
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    vec_t tv[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int wc;
        int nr;
        int nw;
        int got;
        logic [31:0] v;
        logic [31:0] sv[2];
        logic [31:0] sat_y1;

        tv[0] = '{32'sd1024,  32'sd178};
        tv[1] = '{32'sd0,     32'sd293};
        tv[2] = '{32'sd0,     32'sd190};
        tv[3] = '{32'sd2048,  32'sd479};
        tv[4] = '{-32'sd1024, 32'sd489};
        tv[5] = '{32'sd0,     32'sd140};
        tv[6] = '{32'sd0,     32'sd0};
        // last row: T1=dq(178*0)=0, T2=dq(666*140)=91
        tv[6].y = 32'sd91;

`ifdef IIR_SAT_EN
        sat_y1 = 32'h7FFF_FFFF;
`else
        sat_y1 = 32'hFFFF_FFFE;
`endif

        @(negedge clock);
        do_reset();

        // saturation instance: two full-scale samples
        s_dout  = 32'sh7FFF_FFFF;
        s_empty = 1'b0;
        got     = 0;
        sv[0]   = 'x;
        sv[1]   = 'x;
        for (int i = 0; i < 60 && got < 2; i++) begin
            #1;
            if (s_wr) begin
                sv[got] = s_din;
                got++;
            end
            @(negedge clock);
        end
        s_empty = 1'b1;
        chk("sat_cnt", got, 32'd2);
        chk("sat_y0", sv[0], 32'h7FFF_FFFF);
        chk("sat_y1", sv[1], sat_y1);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            push(tv[i].x, rc);
            wait_wr(v, wc);
            chk($sformatf("vec%0d", i), v, tv[i].y);
            chk($sformatf("lat%0d", i), wc - rc, 32'd4);
        end

        // back-pressure with a sample waiting upstream
        do_reset();
        out_full = 1'b1;
        push(32'sd1024, rc);
        in_dout  = 32'sd5;
        in_empty = 1'b0;
        nr = n_rd;
        nw = n_wr;
        repeat (13) @(negedge clock);
        chk("bp_rd", n_rd - nr, 32'd0);
        chk("bp_wr", n_wr - nw, 32'd0);
        out_full = 1'b0;
        wait_wr(v, wc);
        in_empty = 1'b1;
        chk("bp_val", v, 32'sd178);
        chk("bp_when", wc - rc, 32'd14);

        // empty input keeps history
        do_reset();
        push(32'sd1024, rc);
        wait_wr(v, wc);
        chk("emp_y0", v, 32'sd178);
        nr = n_rd;
        nw = n_wr;
        repeat (20) @(negedge clock);
        chk("emp_rd", n_rd - nr, 32'd0);
        chk("emp_wr", n_wr - nw, 32'd0);
        push(32'sd0, rc);
        wait_wr(v, wc);
        chk("emp_y1", v, 32'sd293);

        // floor rounding of a small negative product
        do_reset();
        push(-32'sd1, rc);
        wait_wr(v, wc);
        chk("neg_y", v, -32'sd1);

        // reset while the sample is in the MAC phase
        do_reset();
        nw = n_wr;
        push(32'sd1024, rc);
        do_reset();
        repeat (10) @(negedge clock);
        chk("mrst_wr", n_wr - nw, 32'd0);
        push(32'sd1024, rc);
        wait_wr(v, wc);
        chk("mrst_y", v, 32'sd178);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iir_deemph.md
IIR_DEEMPH -- requirements
Module: iir_deemph

Interface
REQ-001 SHALL have parameter QUANT_BITS, default 10: fixed-point fraction bits of all coefficients.
REQ-002 SHALL have parameter B0, default 32'sd178: signed coefficient applied to x[n].
REQ-003 SHALL have parameter B1, default 32'sd178: signed coefficient applied to x[n-1].
REQ-004 SHALL have parameter A1, default 32'sd666: signed feedback coefficient applied to y[n-1], added.
REQ-005 SHALL have port clock  input  1: single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port in_rd_en  output  1: pops one sample from the upstream FIFO (subtractor output FIFO).
REQ-008 SHALL have port in_empty  input  1: upstream FIFO empty.
REQ-009 SHALL have port in_dout  input  32 signed: upstream sample x[n], valid when in_empty low.
REQ-010 SHALL have port out_wr_en  output  1: pushes one sample to the downstream FIFO.
REQ-011 SHALL have port out_full  input  1: downstream FIFO full.
REQ-012 SHALL have port out_din  output  32 signed: filtered sample y[n], valid only while out_wr_en high.

Function
REQ-013 SHALL compute y[n] = T0 + T1 + T2, with T0 = dq(B0*x[n]), T1 = dq(B1*x[n-1]), T2 = dq(A1*y[n-1]).
REQ-014 dq(p) SHALL be the full 64-bit signed product arithmetically shifted right by QUANT_BITS (floor), truncated to 32 bits.
REQ-015 The sum SHALL be 32-bit two's-complement wrapping, unless IIR_SAT_EN is defined (REQ-026).
REQ-016 SHALL use a three-state FSM: S_IDLE, S_MAC, S_WRITE; one shared 32x32 multiplier, one product per cycle.
REQ-017 S_IDLE: when in_empty low, assert in_rd_en for exactly one cycle, capture in_dout as x_cur, clear accumulator and term index, go to S_MAC; otherwise hold with in_rd_en low.
REQ-018 S_MAC: on each of three consecutive cycles add term index 0,1,2 (T0,T1,T2) to the accumulator; after index 2 go to S_WRITE.
REQ-019 S_WRITE: when out_full low, assert out_wr_en with out_din = accumulator, update x_prev <= x_cur and y_prev <= out_din, go to S_IDLE; when out_full high, hold state, accumulator, and history.
REQ-020 Latency: in_rd_en at cycle T yields earliest out_wr_en at T+4; peak throughput one sample per 5 cycles.
REQ-021 in_rd_en SHALL never be high outside S_IDLE; out_wr_en SHALL never be high outside S_WRITE; the two SHALL never be high together.
REQ-022 out_din SHALL be 0 whenever out_wr_en is low.

Reset
REQ-023 On reset high at a clock edge: state <= S_IDLE; x_cur, x_prev, y_prev, accumulator, term index <= 0.
REQ-024 During and on the cycle after reset, in_rd_en, out_wr_en, and out_din SHALL be 0.
REQ-025 Reset during S_MAC or S_WRITE SHALL discard the in-flight sample; it is never written.

Configuration
REQ-026 With macro IIR_SAT_EN defined, the three-term sum SHALL use 34-bit arithmetic and clamp to [-2^31, 2^31-1]; without it, the sum SHALL wrap per REQ-015, with no extra logic.

Structure
REQ-027 QUANT_BITS default, B0/B1/A1 defaults, and the FSM state typedef SHALL live in the shared global package.
REQ-028 The multiply-plus-dequantize SHALL be a sub-module iir_term_mult: combinational, 32x32 signed in, 32 signed out, parameter QUANT_BITS.

Verification
REQ-029 Impulse, defaults: inputs 1024, 0, 0 -> outputs 178, 293 (178+115), 190 (dq(666*293)=190).
REQ-030 Back-pressure: hold out_full high for 10 cycles while in S_WRITE -> out_wr_en and in_rd_en low throughout; the same value is written in the first cycle out_full is low.
REQ-031 Empty input: in_empty high for 20 cycles -> no in_rd_en, no out_wr_en, history unchanged.
REQ-032 Saturation: B0=B1=1024, A1=0, inputs 0x7FFFFFFF twice -> second output 0x7FFFFFFF with IIR_SAT_EN; 0xFFFFFFFE without it.
REQ-033 Negative rounding: defaults, single input -1 from reset -> output -1 (floor of -178/1024).
REQ-034 Reset mid-S_MAC after input 1024 -> no write; next input 1024 -> output 178 (history cleared).
